// File: rtl/sdhc_register_bank_if.sv
// rtl/sdhc_register_bank_if.sv - host register port bundle for sdhc_register_bank
interface sdhc_register_bank_if;
  logic [7:0]  Host_Addr;
  logic        Host_Wr_En;
  logic [15:0] Host_Wdata;
  logic        Host_Rd_En;
  logic [15:0] Host_Rdata;

  modport master (
    output Host_Addr,
    output Host_Wr_En,
    output Host_Wdata,
    output Host_Rd_En,
    input  Host_Rdata
  );

  modport slave (
    input  Host_Addr,
    input  Host_Wr_En,
    input  Host_Wdata,
    input  Host_Rd_En,
    output Host_Rdata
  );
endinterface

// File: rtl/sdhc_register_bank.sv
// rtl/sdhc_register_bank.sv - SD host transfer register bank and transfer tracker
// Optional feature macro: SDHC_GAP_STOP_EN (stop-at-block-gap, GAP_STOP state, Xfer_Paused, BGC bits 0/1)
module sdhc_register_bank (
  input  logic                   CLK,
  input  logic                   RESET_L,
  sdhc_register_bank_if.slave    host,
  input  logic                   Block_Done,
  output logic [15:0]            Block_Size_Register,
  output logic [15:0]            Block_Count_Register,
  output logic [15:0]            Transfer_Mode_Register,
  output logic [15:0]            Command_Register,
  output logic [31:0]            Present_State_Register,
  output logic [7:0]             Block_Gap_Control_Register,
  output logic                   Xfer_Complete,
  output logic                   Xfer_Paused
);

  localparam logic [7:0] A_BSZ = 8'h04;
  localparam logic [7:0] A_BC  = 8'h06;
  localparam logic [7:0] A_TM  = 8'h0C;
  localparam logic [7:0] A_CMD = 8'h0E;
  localparam logic [7:0] A_PSL = 8'h24;
  localparam logic [7:0] A_PSH = 8'h26;
  localparam logic [7:0] A_BGC = 8'h2A;

`ifdef SDHC_GAP_STOP_EN
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_GAP_STOP} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE} state_t;
`endif

  state_t      r_state;
  state_t      w_next;

  logic [11:0] r_bsz;
  logic [15:0] r_bc;
  logic [3:0]  r_tm;       // {multi-block, direction, block count enable, DMA enable}
  logic [15:0] r_cmd;
  logic [1:0]  r_ps;       // Present State bits 9:8
  logic [15:0] r_rdata;
  logic        r_complete;

  logic        w_idle;
  logic        w_wr_bsz;
  logic        w_wr_bc;
  logic        w_wr_tm;
  logic        w_wr_cmd;
  logic        w_last;
  logic        w_dec;
  logic        w_set_dir;
  logic        w_clr_dir;
  logic        w_complete;
  logic [15:0] w_tm_full;
  logic [7:0]  w_bgc_full;
  logic [15:0] w_rd_mux;

`ifdef SDHC_GAP_STOP_EN
  logic [1:0]  r_bgc;
  logic        r_paused;
  logic        w_wr_bgc;

  assign w_wr_bgc   = host.Host_Wr_En && (host.Host_Addr == A_BGC);
  assign w_bgc_full = {6'd0, r_bgc};
  assign Xfer_Paused = r_paused;
`else
  assign w_bgc_full = 8'h00;
  assign Xfer_Paused = 1'b0;
`endif

  // Transfer-defining registers are frozen while a transfer is in flight
  assign w_idle   = (r_state == ST_IDLE);
  assign w_wr_bsz = host.Host_Wr_En && (host.Host_Addr == A_BSZ) && w_idle;
  assign w_wr_bc  = host.Host_Wr_En && (host.Host_Addr == A_BC)  && w_idle;
  assign w_wr_tm  = host.Host_Wr_En && (host.Host_Addr == A_TM)  && w_idle;
  assign w_wr_cmd = host.Host_Wr_En && (host.Host_Addr == A_CMD) && w_idle;

  // Single-block mode always ends after one block; counted mode ends on the final count
  assign w_last = !r_tm[3] || (r_tm[1] && (r_bc == 16'd1));
  assign w_dec  = (r_state == ST_ACTIVE) && Block_Done && r_tm[1] && (r_bc != 16'd0);

  assign w_tm_full = {10'd0, r_tm[3], r_tm[2], 2'b00, r_tm[1], r_tm[0]};

  // Next-state and transfer event decode
  always_comb begin
    w_next     = r_state;
    w_set_dir  = 1'b0;
    w_clr_dir  = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_cmd) begin
          if (r_tm[3] && r_tm[1] && (r_bc == 16'd0)) begin
            w_complete = 1'b1;
          end else begin
            w_next    = ST_ACTIVE;
            w_set_dir = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (Block_Done) begin
          if (w_last) begin
            w_next     = ST_IDLE;
            w_clr_dir  = 1'b1;
            w_complete = 1'b1;
          end
`ifdef SDHC_GAP_STOP_EN
          else if (r_bgc[0]) begin
            w_next    = ST_GAP_STOP;
            w_clr_dir = 1'b1;
          end
`endif
        end
      end
`ifdef SDHC_GAP_STOP_EN
      ST_GAP_STOP: begin
        if (w_wr_bgc && host.Host_Wdata[1]) begin
          w_next    = ST_ACTIVE;
          w_set_dir = 1'b1;
        end
      end
`endif
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Host-programmed transfer registers and block count tracking
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_bsz <= '0;
      r_bc  <= '0;
      r_tm  <= '0;
      r_cmd <= '0;
    end else begin
      if (w_wr_bsz) r_bsz <= host.Host_Wdata[11:0];
      if (w_wr_tm)  r_tm  <= {host.Host_Wdata[5], host.Host_Wdata[4],
                              host.Host_Wdata[1], host.Host_Wdata[0]};
      if (w_wr_cmd) r_cmd <= host.Host_Wdata;
      if (w_wr_bc) begin
        r_bc <= host.Host_Wdata;
      end else if (w_dec) begin
        r_bc <= r_bc - 16'd1;
      end
    end
  end

  // Present State direction bits and the completion pulse
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_ps       <= 2'b00;
      r_complete <= 1'b0;
    end else begin
      r_complete <= w_complete;
      if (w_set_dir) begin
        r_ps <= r_tm[2] ? 2'b10 : 2'b01;
      end else if (w_clr_dir) begin
        r_ps <= 2'b00;
      end
    end
  end

`ifdef SDHC_GAP_STOP_EN
  // Block gap control: continue bit lives for one cycle; pause flag tracks GAP_STOP
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_bgc    <= 2'b00;
      r_paused <= 1'b0;
    end else begin
      r_paused <= (w_next == ST_GAP_STOP);
      if (w_wr_bgc) begin
        r_bgc <= host.Host_Wdata[1:0];
      end else begin
        r_bgc[1] <= 1'b0;
      end
    end
  end
`endif

  // Read decode on pre-write register values
  always_comb begin
    w_rd_mux = 16'h0000;
    case (host.Host_Addr)
      A_BSZ:   w_rd_mux = {4'd0, r_bsz};
      A_BC:    w_rd_mux = r_bc;
      A_TM:    w_rd_mux = w_tm_full;
      A_CMD:   w_rd_mux = r_cmd;
      A_PSL:   w_rd_mux = {6'd0, r_ps, 8'd0};
      A_PSH:   w_rd_mux = 16'h0000;
      A_BGC:   w_rd_mux = {8'd0, w_bgc_full};
      default: w_rd_mux = 16'h0000;
    endcase
  end

  // Read data register holds until the next read strobe
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_rdata <= '0;
    end else if (host.Host_Rd_En) begin
      r_rdata <= w_rd_mux;
    end
  end

  assign host.Host_Rdata                = r_rdata;
  assign Block_Size_Register            = {4'd0, r_bsz};
  assign Block_Count_Register           = r_bc;
  assign Transfer_Mode_Register         = w_tm_full;
  assign Command_Register               = r_cmd;
  assign Present_State_Register         = {22'd0, r_ps, 8'd0};
  assign Block_Gap_Control_Register     = w_bgc_full;
  assign Xfer_Complete                  = r_complete;

endmodule
